// File: rtl/cpu_pkg.sv
// Shared types and constants for the 9-bit-instruction, 8-bit-datapath processor.
package cpu_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned RA_W    = 2;

    typedef enum logic [2:0] {
        ALU  = 3'b000,
        MISC = 3'b001,
        LW   = 3'b010,
        SW   = 3'b011,
        LI   = 3'b100,
        ADDI = 3'b101,
        BZ   = 3'b110,
        BNZ  = 3'b111
    } opcode_e;

    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_AND  = 2'b10;
    localparam logic [1:0] FN_XOR  = 2'b11;
    localparam logic [1:0] FN_SHL  = 2'b00;
    localparam logic [1:0] FN_SHR  = 2'b01;
    localparam logic [1:0] FN_MOV  = 2'b10;
    localparam logic [1:0] FN_HALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef struct packed {
        opcode_e         op;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs;
        logic [1:0]      fn;
    } instr_t;

    function automatic logic [DATA_W-1:0] sext4(input logic [3:0] v);
        return {{(DATA_W-4){v[3]}}, v};
    endfunction

endpackage

// File: rtl/top_level_cpu_core.sv
// Single-cycle core: decode, ALU, branch/pc logic and IDLE/RUN/DONE sequencing.
module cpu_core
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_word,
    input  logic [DATA_W-1:0]  d_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               d_we,
    output logic [7:0]         d_addr,
    output logic [DATA_W-1:0]  d_wdata,
    output logic               done
);

    state_e            state;
    instr_t            ins;
    logic [3:0]        imm4;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic              halt;
    logic              take;

    assign ins  = instr_t'(instr_word);
    assign imm4 = {ins.rs, ins.fn};

    reg_file rf (
        .clk     (clk),
        .reset   (reset),
        .ra      (ins.rd),
        .rb      (ins.rs),
        .ra_data (rd_val),
        .rb_data (rs_val),
        .we      (wb_en),
        .wa      (ins.rd),
        .wdata   (wb_data)
    );

    // Decode/execute; all side effects are gated to the RUN state.
    always_comb begin
        wb_en   = 1'b0;
        wb_data = rd_val;
        halt    = 1'b0;
        take    = 1'b0;
        case (ins.op)
            ALU: begin
                wb_en = 1'b1;
                case (ins.fn)
                    FN_ADD:  wb_data = rd_val + rs_val;
                    FN_SUB:  wb_data = rd_val - rs_val;
                    FN_AND:  wb_data = rd_val & rs_val;
                    default: wb_data = rd_val ^ rs_val;
                endcase
            end
            MISC: begin
                case (ins.fn)
                    FN_SHL: begin
                        wb_en   = 1'b1;
                        wb_data = {rd_val[DATA_W-2:0], 1'b0};
                    end
                    FN_SHR: begin
                        wb_en   = 1'b1;
                        wb_data = {1'b0, rd_val[DATA_W-1:1]};
                    end
                    FN_MOV: begin
                        wb_en   = 1'b1;
                        wb_data = rs_val;
                    end
                    default: halt = 1'b1;
                endcase
            end
            LW: begin
                wb_en   = 1'b1;
                wb_data = d_rdata;
            end
            SW: wb_en = 1'b0;
            LI: begin
                wb_en   = 1'b1;
                wb_data = DATA_W'(imm4);
            end
            ADDI: begin
                wb_en   = 1'b1;
                wb_data = rd_val + sext4(imm4);
            end
            BZ:  take = (rd_val == '0);
            BNZ: take = (rd_val != '0);
        endcase
        if (state != RUN) begin
            wb_en = 1'b0;
            halt  = 1'b0;
        end
    end

    assign d_we    = (state == RUN) && (ins.op == SW);
    assign d_addr  = rs_val;
    assign d_wdata = rd_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (halt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (take) begin
                        pc <= pc + sext4(imm4);
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= '0;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/top_level_cpu_data_mem.sv
// Data memory: combinational read, synchronous write, contents not reset.
module data_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/top_level_cpu_reg_file.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   ra,
    input  logic [RA_W-1:0]   rb,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [0:3];

    assign ra_data = regs[ra];
    assign rb_data = regs[rb];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wdata;
        end
    end

endmodule

// File: rtl/top_level_cpu.sv
// Processor top: instruction ROM, core and data memory.
module top_level_cpu
    import cpu_pkg::*;
#(
    parameter string       PROG_FILE  = "prog.bin",
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    logic [INSTR_W-1:0] rom [0:255];
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr_word;
    logic               d_we;
    logic [7:0]         d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic [DATA_W-1:0]  d_rdata;

    assign instr_word = rom[pc];

    cpu_core cpu (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr_word (instr_word),
        .d_rdata    (d_rdata),
        .pc         (pc),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .done       (done)
    );

    data_mem #(.DEPTH(DMEM_DEPTH)) data_mem_i (
        .clk   (clk),
        .we    (d_we),
        .addr  (d_addr),
        .wdata (d_wdata),
        .rdata (d_rdata)
    );

endmodule

// File: tb/tb_top_level_cpu.sv
// Directed bench for top_level_cpu: table of programs with expected results plus control corner cases.
module tb_top_level_cpu;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic done;

    int checks = 0;
    int errors = 0;
    int store_cnt = 0;
    logic [7:0] st_addr = '0;
    logic [7:0] st_data = '0;

    top_level_cpu #(.PROG_FILE(""), .DMEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Stores are observed mid-cycle, before the edge that commits them.
    always @(negedge clk) begin
        if (dut.d_we === 1'b1) begin
            store_cnt = store_cnt + 1;
            st_addr   = dut.d_addr;
            st_data   = dut.d_wdata;
        end
    end

    localparam logic [8:0] HALT_I = 9'b001_00_00_11;

    function automatic logic [8:0] f_alu(input logic [1:0] fn, input logic [1:0] rd, input logic [1:0] rs);
        return {3'b000, rd, rs, fn};
    endfunction
    function automatic logic [8:0] f_misc(input logic [1:0] fn, input logic [1:0] rd, input logic [1:0] rs);
        return {3'b001, rd, rs, fn};
    endfunction
    function automatic logic [8:0] f_lw(input logic [1:0] rd, input logic [1:0] rs);
        return {3'b010, rd, rs, 2'b00};
    endfunction
    function automatic logic [8:0] f_sw(input logic [1:0] rd, input logic [1:0] rs);
        return {3'b011, rd, rs, 2'b00};
    endfunction
    function automatic logic [8:0] f_li(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b100, rd, imm};
    endfunction
    function automatic logic [8:0] f_addi(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b101, rd, imm};
    endfunction
    function automatic logic [8:0] f_bz(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b110, rd, imm};
    endfunction
    function automatic logic [8:0] f_bnz(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b111, rd, imm};
    endfunction

    typedef struct packed {
        logic [7:0]       cycles;
        logic [7:0]       stores;
        logic [7:0]       s_addr;
        logic [7:0]       s_data;
        logic [7:0]       probe_cyc;
        logic [1:0]       probe_reg;
        logic [7:0]       probe_val;
        logic [3:0][7:0]  regs;
    } vec_t;

    localparam int NPROG = 6;
    logic [8:0] progs [NPROG][8];
    vec_t       tbl   [NPROG];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic load_prog(input int idx);
        for (int i = 0; i < 256; i++) dut.rom[i] = (i < 8) ? progs[idx][i] : HALT_I;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Count RUN edges until done rises; probes one register at a chosen cycle.
    task automatic wait_done(input int idx, input bit noisy, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (noisy) start = (cyc >= 1 && cyc <= 3);
            @(posedge clk); #1;
            cyc = cyc + 1;
            if (cyc == int'(tbl[idx].probe_cyc))
                check($sformatf("prog%0d probe R%0d", idx, tbl[idx].probe_reg),
                      32'(dut.cpu.rf.regs[tbl[idx].probe_reg]), 32'(tbl[idx].probe_val));
        end
        start = 1'b0;
    endtask

    task automatic run_prog(input int idx, input bit noisy);
        int cyc;
        int st_hold;
        logic [7:0] pc_hold;
        load_prog(idx);
        do_reset();
        store_cnt = 0;
        pulse_start();
        wait_done(idx, noisy, cyc);
        check($sformatf("prog%0d cycles", idx), 32'(cyc), 32'(tbl[idx].cycles));
        check($sformatf("prog%0d done", idx), 32'(done), 32'd1);
        check($sformatf("prog%0d stores", idx), 32'(store_cnt), 32'(tbl[idx].stores));
        if (tbl[idx].stores != 0) begin
            check($sformatf("prog%0d store addr", idx), 32'(st_addr), 32'(tbl[idx].s_addr));
            check($sformatf("prog%0d store data", idx), 32'(st_data), 32'(tbl[idx].s_data));
            check($sformatf("prog%0d mem", idx),
                  32'(dut.data_mem_i.mem[tbl[idx].s_addr]), 32'(tbl[idx].s_data));
        end
        for (int r = 0; r < 4; r++)
            check($sformatf("prog%0d R%0d", idx, r), 32'(dut.cpu.rf.regs[r]), 32'(tbl[idx].regs[r]));
        pc_hold = dut.pc;
        st_hold = store_cnt;
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("prog%0d pc frozen", idx), 32'(dut.pc), 32'(pc_hold));
        check($sformatf("prog%0d done held", idx), 32'(done), 32'd1);
        check($sformatf("prog%0d no stores in DONE", idx), 32'(store_cnt), 32'(st_hold));
    endtask

    initial begin
        int cyc;

        // 0: arithmetic and store
        progs[0] = '{f_li(2'd1, 4'd5), f_li(2'd2, 4'd7), f_alu(2'b00, 2'd1, 2'd2), f_li(2'd0, 4'd2),
                     f_sw(2'd1, 2'd0), HALT_I, HALT_I, HALT_I};
        tbl[0]   = '{cycles: 8'd6, stores: 8'd1, s_addr: 8'h02, s_data: 8'h0C,
                     probe_cyc: 8'd3, probe_reg: 2'd1, probe_val: 8'h0C, regs: 32'h00070C02};
        // 1: load and shift
        progs[1] = '{f_li(2'd0, 4'd1), f_lw(2'd1, 2'd0), f_misc(2'b00, 2'd1, 2'd0), f_li(2'd3, 4'd3),
                     f_sw(2'd1, 2'd3), HALT_I, HALT_I, HALT_I};
        tbl[1]   = '{cycles: 8'd6, stores: 8'd1, s_addr: 8'h03, s_data: 8'h06,
                     probe_cyc: 8'd2, probe_reg: 2'd1, probe_val: 8'h03, regs: 32'h03000601};
        // 2: countdown loop
        progs[2] = '{f_li(2'd0, 4'd3), f_addi(2'd0, 4'hF), f_bnz(2'd0, 4'hF), HALT_I,
                     HALT_I, HALT_I, HALT_I, HALT_I};
        tbl[2]   = '{cycles: 8'd8, stores: 8'd0, s_addr: 8'h00, s_data: 8'h00,
                     probe_cyc: 8'd2, probe_reg: 2'd0, probe_val: 8'h02, regs: 32'h00000000};
        // 3: modulo wrap
        progs[3] = '{f_li(2'd1, 4'd0), f_addi(2'd1, 4'hF), f_alu(2'b01, 2'd1, 2'd1), HALT_I,
                     HALT_I, HALT_I, HALT_I, HALT_I};
        tbl[3]   = '{cycles: 8'd4, stores: 8'd0, s_addr: 8'h00, s_data: 8'h00,
                     probe_cyc: 8'd2, probe_reg: 2'd1, probe_val: 8'hFF, regs: 32'h00000000};
        // 4: BZ taken/not taken, SHR, MOV
        progs[4] = '{f_li(2'd2, 4'd0), f_bz(2'd2, 4'd2), f_li(2'd3, 4'd9), f_li(2'd1, 4'hF),
                     f_misc(2'b01, 2'd1, 2'd0), f_misc(2'b10, 2'd0, 2'd1), f_bz(2'd1, 4'hA), HALT_I};
        tbl[4]   = '{cycles: 8'd7, stores: 8'd0, s_addr: 8'h00, s_data: 8'h00,
                     probe_cyc: 8'd3, probe_reg: 2'd1, probe_val: 8'h0F, regs: 32'h00000707};
        // 5: AND / XOR
        progs[5] = '{f_li(2'd0, 4'hC), f_li(2'd1, 4'hA), f_misc(2'b10, 2'd2, 2'd0), f_alu(2'b10, 2'd0, 2'd1),
                     f_alu(2'b11, 2'd2, 2'd1), HALT_I, HALT_I, HALT_I};
        tbl[5]   = '{cycles: 8'd6, stores: 8'd0, s_addr: 8'h00, s_data: 8'h00,
                     probe_cyc: 8'd3, probe_reg: 2'd2, probe_val: 8'h0C, regs: 32'h00060A08};

        // Reset state and memory retention
        load_prog(0);
        dut.data_mem_i.mem[0] = 8'hAA;
        dut.data_mem_i.mem[1] = 8'h55;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset done", 32'(done), 32'd0);
        check("reset pc", 32'(dut.pc), 32'd0);
        for (int r = 0; r < 4; r++)
            check($sformatf("reset R%0d", r), 32'(dut.cpu.rf.regs[r]), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle pc", 32'(dut.pc), 32'd0);
        check("reset mem0", 32'(dut.data_mem_i.mem[0]), 32'hAA);
        check("reset mem1", 32'(dut.data_mem_i.mem[1]), 32'h55);

        dut.data_mem_i.mem[0] = 8'h00;
        dut.data_mem_i.mem[1] = 8'h03;
        for (int p = 0; p < NPROG; p++) run_prog(p, 1'b0);

        // start pulses while running are ignored
        dut.data_mem_i.mem[2] = 8'h00;
        run_prog(0, 1'b1);

        // restart from DONE reruns the program
        dut.data_mem_i.mem[2] = 8'h00;
        store_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart done low", 32'(done), 32'd0);
        check("restart pc", 32'(dut.pc), 32'd0);
        wait_done(0, 1'b0, cyc);
        check("restart cycles", 32'(cyc), 32'd6);
        check("restart stores", 32'(store_cnt), 32'd1);
        check("restart mem2", 32'(dut.data_mem_i.mem[2]), 32'h0C);

        // reset mid-run aborts before the store
        load_prog(0);
        do_reset();
        dut.data_mem_i.mem[2] = 8'h33;
        store_cnt = 0;
        pulse_start();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrun reset done", 32'(done), 32'd0);
        check("midrun reset pc", 32'(dut.pc), 32'd0);
        check("midrun reset R1", 32'(dut.cpu.rf.regs[1]), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrun no stores", 32'(store_cnt), 32'd0);
        check("midrun mem2", 32'(dut.data_mem_i.mem[2]), 32'h33);
        check("midrun idle pc", 32'(dut.pc), 32'd0);
        check("midrun idle done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/top_level_cpu.md
Name: top_level_cpu

Overview:
- Self-contained 9-bit-instruction, 8-bit-datapath single-cycle processor.
- Contains an instruction ROM, a 4x8 register file and a 256x8 data memory.
- Idles until a start pulse, executes from PC 0 until HALT, then raises done.
- Top of the accelerator; the bench preloads operands into data memory before start.

Parameters:
- PROG_FILE, "prog.bin", $readmemb image for the 256x9 instruction ROM
- DMEM_DEPTH, 256, data memory words (8-bit); address is 8 bits

Ports:
- clk  input  1  single rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  run request, sampled on rising clk
- done  output  1  high once HALT has executed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=0, done=0, regs R0-R3=0.
  - Data memory is not cleared; contents survive reset.
- FSM:
  - IDLE: pc held at 0. start=1 -> RUN.
  - RUN: one instruction per cycle.
    - HALT -> DONE. done=1 from the edge that retires HALT.
  - DONE: pc frozen, no writes. start=1 -> RUN from pc=0, done=0 on that edge. Registers are not cleared.
  - start in RUN is ignored.
- Instruction format: [8:6] op, [5:4] rd, [3:2] rs, [1:0] fn, imm4=[3:0].
- Opcodes:
  - 000 ALU: rd <= rd OP rs. fn 00 ADD, 01 SUB, 10 AND, 11 XOR.
  - 001 MISC: fn 00 SHL1 rd, 01 SHR1 rd (logical), 10 MOV rd<=rs, 11 HALT.
  - 010 LW: rd <= dmem[R[rs]].
  - 011 SW: dmem[R[rs]] <= R[rd].
  - 100 LI: rd <= {4'b0, imm4}.
  - 101 ADDI: rd <= rd + sext(imm4).
  - 110 BZ: if R[rd]==0, pc <= pc+sext(imm4), else pc+1.
  - 111 BNZ: if R[rd]!=0, pc <= pc+sext(imm4), else pc+1.
- Arithmetic: all 8-bit modulo 256, no flags; pc is 8 bits and wraps 255->0.
- Memories:
  - Instruction ROM: combinational read.
  - Data memory: combinational read; synchronous write on clk when d_we=1.
  - d_we is asserted only in RUN for SW.
- Register write is synchronous; the same-cycle read sees the old value.
- Internal names the bench probes (mandatory):
  - pc, instr_word, d_we, d_addr, d_wdata
  - instance data_mem_i with array mem
  - instance cpu containing instance rf with array regs[0:3]

Decomposition:
- Package cpu_pkg:
  - opcode enum (ALU, MISC, LW, SW, LI, ADDI, BZ, BNZ)
  - fn constants
  - state enum (IDLE, RUN, DONE)
  - widths: INSTR_W=9, DATA_W=8, PC_W=8
- Sub-modules:
  - cpu core (decoder, ALU, pc, FSM) containing reg_file as rf
  - data_mem instanced as data_mem_i
  - instr ROM may be inline

Test Plan:
- Reset: hold reset=0 for 2 cycles -> done=0, pc=00, R0..R3=0; preloaded mem[0..1] unchanged.
- Arithmetic: program LI R1,5; LI R2,7; ADD R1,R2; LI R0,2; SW R1,[R0]; HALT; pulse start.
  - -> exactly one store, mem[2]=0C.
  - done=1 on the 6th RUN edge.
- Load/shift: mem[1]=03, mem[0]=00. Program LI R0,1; LW R1,[R0]; SHL R1; LI R3,3; SW R1,[R3]; HALT.
  - -> mem[3]=06, R1=6.
- Loop: LI R0,3; ADDI R0,-1; BNZ R0,-1; HALT -> R0=0, done after 8 RUN cycles, no stores.
- Wrap: LI R1,0; ADDI R1,-1; SUB R1,R1 -> R1 goes FF then 00.
- Control:
  - start pulses during RUN -> ignored, result unchanged.
  - start after done -> done=0 next edge, program reruns.
  - reset=0 mid-run -> done=0, pc=00 immediately, no further stores.
